// File: rtl/rom_loader_pkg.sv
// Shared types and sizing constants for the boot-time ROM loader.
package rom_loader_pkg;

  localparam int LEN_W          = 16;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    SUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/rom_loader.sv
// Boot loader: assembles little-endian words from the UART byte stream into ROM,
// verifies an XOR checksum and holds the CPU in reset until a valid image is loaded.
//
// state | meaning
// LEN0  | waiting for length low byte
// LEN1  | waiting for length high byte
// DATA  | collecting instruction bytes, writing one word per 4 bytes
// SUM   | waiting for checksum byte
// DONE  | image valid, CPU released; next byte starts a reload
// ERR   | oversize length or bad checksum; next byte starts a reload
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W:0] CAPACITY = (LEN_W + 1)'(1) << ADDR_W;

  loader_state_t     state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        acc_q, acc_d;
  logic [23:0]       buf_q, buf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [LEN_W-1:0]  len_new;

  assign len_new = {rx_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    buf_d   = buf_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (rx_valid) begin
      unique case (state_q)
        LEN0, DONE, ERR: begin
          len_d   = {len_q[15:8], rx_data};
          state_d = LEN1;
        end
        LEN1: begin
          len_d = len_new;
          cnt_d = '0;
          idx_d = '0;
          acc_d = '0;
          if (len_new == '0)                  state_d = SUM;
          else if ({1'b0, len_new} > CAPACITY) state_d = ERR;
          else                                 state_d = DATA;
        end
        DATA: begin
          acc_d = acc_q ^ rx_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = cnt_q;
            wdata_d = {rx_data, buf_q};
            cnt_d   = cnt_q + 1'b1;
            // Compare against len-1 so a full-capacity image ends cleanly as the counter wraps.
            if (LEN_W'(cnt_q) == len_q - LEN_W'(1)) state_d = SUM;
          end else begin
            buf_d[{idx_q, 3'b000} +: 8] = rx_data;
          end
        end
        SUM:     state_d = (rx_data == acc_q) ? DONE : ERR;
        default: state_d = LEN0;
      endcase
    end
    hold_d = (state_d != DONE);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LEN0;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      buf_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      buf_q   <= buf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rom_we    = we_q;
  assign rom_addr  = addr_q;
  assign rom_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: expected ROM writes are queued by the stimulus
// and matched by an independent monitor on every rom_we pulse.
module tb_rom_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t    sb_q[$];
  logic [7:0] byte_q[$];
  int     checks = 0;
  int     errors = 0;
  logic   prev_we = 1'b0;

  rom_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_w(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = ADDR_W'(a);
    w.data = d;
    sb_q.push_back(w);
  endtask

  // Drive byte_q on consecutive cycles, then idle.
  task automatic drive();
    while (byte_q.size() > 0) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = byte_q.pop_front();
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_status(input string name, input logic exp_done, input logic exp_err);
    int n = 0;
    while (!(done || error) && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({name, ".done"}, 32'(done), 32'(exp_done));
    chk({name, ".error"}, 32'(error), 32'(exp_err));
    chk({name, ".cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    chk({name, ".writes_left"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic base_stream(input logic [7:0] sum);
    byte_q = '{8'h02, 8'h00, 8'h00, 8'h02, 8'h30, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00};
    byte_q.push_back(sum);
    exp_w(0, 32'h00300200);
    exp_w(1, 32'h0000000A);
  endtask

  // Monitor: every rom_we pulse must match the head of the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset && rom_we) begin
        chk("we_single_cycle", 32'(prev_we), 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %h data %h expected no write", rom_addr, rom_wdata);
        end else begin
          wr_t w;
          w = sb_q.pop_front();
          chk("rom_addr", 32'(rom_addr), 32'(w.addr));
          chk("rom_wdata", rom_wdata, w.data);
        end
      end
      prev_we = rom_we && reset;
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.error", 32'(error), 32'd0);
    chk("rst.rom_we", 32'(rom_we), 32'd0);
    chk("rst.rom_addr", 32'(rom_addr), 32'd0);
    chk("rst.rom_wdata", rom_wdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    base_stream(8'h38);
    drive();
    wait_status("good", 1'b1, 1'b0);

    base_stream(8'h39);
    drive();
    wait_status("badsum", 1'b0, 1'b1);

    byte_q = '{8'h01, 8'h02};
    drive();
    wait_status("oversize", 1'b0, 1'b1);

    byte_q = '{8'h00, 8'h00, 8'h00};
    drive();
    wait_status("zero_ok", 1'b1, 1'b0);

    byte_q = '{8'h00, 8'h00, 8'h01};
    drive();
    wait_status("zero_bad", 1'b0, 1'b1);

    base_stream(8'h38);
    drive();
    wait_status("preload", 1'b1, 1'b0);
    byte_q = '{8'h01};
    drive();
    chk("reload.cpu_hold", 32'(cpu_hold), 32'd1);
    chk("reload.done", 32'(done), 32'd0);
    byte_q = '{8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h0A};
    exp_w(0, 32'h0000000A);
    drive();
    wait_status("reload", 1'b1, 1'b0);

    byte_q = '{8'h02, 8'h00, 8'h00, 8'h02, 8'h30, 8'h00};
    exp_w(0, 32'h00300200);
    drive();
    reset = 1'b0;
    @(negedge clk);
    chk("abort.cpu_hold", 32'(cpu_hold), 32'd1);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.rom_we", 32'(rom_we), 32'd0);
    chk("abort.rom_addr", 32'(rom_addr), 32'd0);
    chk("abort.rom_wdata", rom_wdata, 32'd0);
    chk("abort.writes_left", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    base_stream(8'h38);
    drive();
    wait_status("after_abort", 1'b1, 1'b0);

    // Full capacity: word i = i, so checksum = XOR(0..255) = 0.
    byte_q = '{8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      byte_q.push_back(8'(i));
      byte_q.push_back(8'h00);
      byte_q.push_back(8'h00);
      byte_q.push_back(8'h00);
      exp_w(i, 32'(i));
    end
    byte_q.push_back(8'h00);
    drive();
    wait_status("full", 1'b1, 1'b0);

    byte_q = '{8'h01, 8'h01};
    drive();
    wait_status("cap_plus1", 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
